elevator_lcd_ctrl: RTL and testbench
====================================

ELEVATOR_LCD_CTRL -- requirements
Module: elevator_lcd_ctrl

Interface
REQ-001 SHALL have parameter NUM_ELV, default 2, number of elevator rows shown (legal 1..2).
REQ-002 SHALL have parameter NUM_FLOORS, default 9, floors per shaft (legal 2..16; 2..14 with LCD_FLOOR_DIGIT_EN).
REQ-003 SHALL have parameter CLK_DIV, default 2000, clock cycles per LCD byte transaction (legal >= 8).
REQ-004 SHALL have parameter EN_ON, default 200, EN_OFF default 1800, cycle offsets within a transaction where lcd_en rises/falls (0 < EN_ON < EN_OFF < CLK_DIV).
REQ-005 SHALL have parameter PWR_WAIT, default 20000, power-on idle cycles before first command.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 elv_floor  input  5*NUM_ELV  floor of elevator k in bits [5k+4:5k], 1-based.
REQ-009 force_refresh  input  1  single-cycle request to redraw even if floors unchanged.
REQ-010 lcd_rs, lcd_rw, lcd_en  output  1 each  HD44780 control; lcd_rw is constant 0.
REQ-011 lcd_data  output  8  HD44780 data bus.
REQ-012 busy  output  1  high while init or a frame write is in progress.
REQ-013 frame_done  output  1  one-cycle pulse after the last byte of a frame completes.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states: PWR, INIT, IDLE, SETA, WRCH; transitions below only.
REQ-016 PWR: wait PWR_WAIT cycles, then INIT.
REQ-017 INIT: send commands 0x38, 0x38, 0x0C, 0x06, 0x01 (rs=0), one per transaction, then IDLE with refresh pending.
REQ-018 Transaction: lcd_rs/lcd_data stable for all CLK_DIV cycles; lcd_en=1 for offsets EN_ON..EN_OFF-1, else 0.
REQ-019 IDLE: start frame if refresh pending, any elv_floor differs from last-drawn snapshot, or force_refresh=1; else stay, busy=0.
REQ-020 Frame start SHALL latch elv_floor into a snapshot; input changes mid-frame SHALL NOT alter the frame and SHALL trigger the next frame.
REQ-021 Frame: for row r=0..NUM_ELV-1: SETA sends 0x80 (r=0) or 0xC0 (r=1), then WRCH sends 16 characters (rs=1), columns 0..15.
REQ-022 Row r shows elevator r; floor f in 1..NUM_FLOORS puts 0xFF at column 16-f; all other shaft columns 0x20.
REQ-023 Floor 0 or > NUM_FLOORS SHALL render the whole shaft blank (0x20).
REQ-024 After the last character, frame_done pulses one cycle, busy falls the same cycle, return IDLE.
REQ-025 force_refresh during a frame SHALL be held pending and serviced next (one extra frame max).
REQ-026 Frame length SHALL be NUM_ELV*17*CLK_DIV cycles.

Reset
REQ-027 resetn=0 SHALL immediately force: state PWR, counters 0, snapshot 0, pending cleared, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=1, frame_done=0.
REQ-028 Reset mid-transaction SHALL drop lcd_en to 0 asynchronously; after release full PWR/INIT repeats.

Configuration
REQ-029 Macro LCD_FLOOR_DIGIT_EN defined: columns 0..1 show floor as two ASCII decimal digits (leading '0', e.g. 0x30 0x37 for 7); out-of-range floor shows "--" (0x2D 0x2D); shaft columns unchanged.
REQ-030 Macro undefined: columns 0..1 are shaft/blank per REQ-022; no digit logic synthesised.

Verification (CLK_DIV=20, EN_ON=2, EN_OFF=18, PWR_WAIT=100, NUM_ELV=2, NUM_FLOORS=9)
REQ-031 Release reset -> 100 idle cycles, then 0x38,0x38,0x0C,0x06,0x01 each 20 cycles with lcd_en high 16 cycles; first frame follows.
REQ-032 elv_floor={5'd9,5'd1} -> row0 col15=0xFF, row1 col7=0xFF, all else 0x20; frame_done after 680 cycles.
REQ-033 Change elv0 floor 1->4 mid-frame -> current frame still shows col15; next frame shows col12.
REQ-034 Floors unchanged, force_refresh pulse in IDLE -> one identical frame; no pulse -> busy stays 0.
REQ-035 elv0 floor=0 or 12 -> row0 all 0x20; with LCD_FLOOR_DIGIT_EN row0 cols0..1=0x2D,0x2D; floor 7 -> 0x30,0x37.
REQ-036 resetn low at offset 10 of a WRCH transaction -> lcd_en=0 same cycle, outputs at reset values, PWR restarts on release.

Source files
------------

// File: rtl/elevator_lcd_ctrl.sv
// elevator_lcd_ctrl: drives an HD44780 LCD with one 16-column shaft row per elevator.
// Optional macro LCD_FLOOR_DIGIT_EN adds a two-digit floor readout in columns 0..1.
module elevator_lcd_ctrl #(
   parameter int NUM_ELV    = 2,
   parameter int NUM_FLOORS = 9,
   parameter int CLK_DIV    = 2000,
   parameter int EN_ON      = 200,
   parameter int EN_OFF     = 1800,
   parameter int PWR_WAIT   = 20000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [5*NUM_ELV-1:0] elv_floor,
   input  logic                 force_refresh,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_en,
   output logic [7:0]           lcd_data,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int CMAX = (PWR_WAIT > CLK_DIV) ? PWR_WAIT : CLK_DIV;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {PWR, INIT, IDLE, SETA, WRCH} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic                 row_q, row_d;
   logic [3:0]           col_q, col_d;
   logic [5*NUM_ELV-1:0] snap_q, snap_d;
   logic                 pending_q, pending_d;
   logic                 lcd_rs_q, lcd_rs_d;
   logic                 lcd_en_q, lcd_en_d;
   logic [7:0]           lcd_data_q, lcd_data_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 txn_end;
   logic [4:0]           floor_sel;

   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      case (i)
         3'd0, 3'd1: init_cmd = 8'h38;
         3'd2:       init_cmd = 8'h0C;
         3'd3:       init_cmd = 8'h06;
         default:    init_cmd = 8'h01;
      endcase
   endfunction

   // Floor f lights column 16-f, so the top floor sits furthest left.
   function automatic logic [7:0] char_at(input logic [4:0] f, input logic [3:0] c);
      logic valid;
`ifdef LCD_FLOOR_DIGIT_EN
      logic [4:0] ones;
`endif
      valid   = (f != 5'd0) && (f <= 5'(NUM_FLOORS));
      char_at = (valid && ({1'b0, c} == (5'd16 - f))) ? 8'hFF : 8'h20;
`ifdef LCD_FLOOR_DIGIT_EN
      ones = (f >= 5'd10) ? (f - 5'd10) : f;
      if (c == 4'd0) char_at = !valid ? 8'h2D : ((f >= 5'd10) ? 8'h31 : 8'h30);
      if (c == 4'd1) char_at = !valid ? 8'h2D : (8'h30 + {3'b000, ones});
`endif
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= PWR;
         cnt_q      <= '0;
         idx_q      <= '0;
         row_q      <= 1'b0;
         col_q      <= '0;
         snap_q     <= '0;
         pending_q  <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_en_q   <= 1'b0;
         lcd_data_q <= 8'h00;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         col_q      <= col_d;
         snap_q     <= snap_d;
         pending_q  <= pending_d;
         lcd_rs_q   <= lcd_rs_d;
         lcd_en_q   <= lcd_en_d;
         lcd_data_q <= lcd_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      row_d     = row_q;
      col_d     = col_q;
      snap_d    = snap_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      txn_end   = (cnt_q == CW'(CLK_DIV - 1));
      case (state_q)
         PWR: begin
            if (cnt_q == CW'(PWR_WAIT - 1)) begin
               state_d = INIT;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         INIT: begin
            if (txn_end) begin
               cnt_d = '0;
               if (idx_q == 3'd4) begin
                  state_d   = IDLE;
                  pending_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (pending_q || force_refresh || (elv_floor != snap_q)) begin
               state_d   = SETA;
               cnt_d     = '0;
               row_d     = 1'b0;
               col_d     = '0;
               snap_d    = elv_floor;
               pending_d = 1'b0;
            end
         end
         SETA: begin
            if (txn_end) begin
               state_d = WRCH;
               cnt_d   = '0;
               col_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRCH: begin
            if (txn_end) begin
               cnt_d = '0;
               if (col_q == 4'd15) begin
                  if (row_q == 1'(NUM_ELV - 1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = SETA;
                  end
               end else begin
                  col_d = col_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = PWR;
      endcase
      // A refresh request arriving mid-frame is remembered for the following frame.
      if (force_refresh && ((state_q == SETA) || (state_q == WRCH))) pending_d = 1'b1;
   end

   // Outputs are computed from next-state values so the registered bus lines up with the state.
   always_comb begin
      lcd_rs_d   = 1'b0;
      lcd_data_d = 8'h00;
      floor_sel  = snap_d[4:0];
      if (row_d) floor_sel = snap_d[5*NUM_ELV-1 -: 5];
      lcd_en_d   = ((state_d == INIT) || (state_d == SETA) || (state_d == WRCH)) &&
                   (cnt_d >= CW'(EN_ON)) && (cnt_d < CW'(EN_OFF));
      busy_d     = (state_d != IDLE);
      case (state_d)
         INIT: lcd_data_d = init_cmd(idx_d);
         SETA: lcd_data_d = row_d ? 8'hC0 : 8'h80;
         WRCH: begin
            lcd_rs_d   = 1'b1;
            lcd_data_d = char_at(floor_sel, col_d);
         end
         default: lcd_data_d = 8'h00;
      endcase
   end

   assign lcd_rs     = lcd_rs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_en     = lcd_en_q;
   assign lcd_data   = lcd_data_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_elevator_lcd_ctrl.sv
// tb_elevator_lcd_ctrl: table-driven frame checks plus init, mid-frame, refresh and reset sequences.
module tb_elevator_lcd_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic [9:0] elv_floor;
   logic       force_refresh;
   logic       lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;
   logic       busy, frame_done;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [4:0]  f0;
      logic [4:0]  f1;
      int          c0;
      int          c1;
      logic [15:0] d0;
      logic [15:0] d1;
   } vec_t;

   vec_t       vecs[6];
   logic [8:0] q[$];
   logic       en_prev = 1'b0;

   elevator_lcd_ctrl #(
      .NUM_ELV(2), .NUM_FLOORS(9), .CLK_DIV(20), .EN_ON(2), .EN_OFF(18), .PWR_WAIT(100)
   ) dut (
      .clk(clk), .resetn(resetn), .elv_floor(elv_floor), .force_refresh(force_refresh),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Record one {rs,data} byte per lcd_en rising edge.
   always @(negedge clk) begin
      if (lcd_en && !en_prev) q.push_back({lcd_rs, lcd_data});
      en_prev = lcd_en;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] exp_char(input int col, input int mark, input logic [15:0] dig);
`ifdef LCD_FLOOR_DIGIT_EN
      if (col == 0) return dig[15:8];
      if (col == 1) return dig[7:0];
`endif
      return (col == mark) ? 8'hFF : 8'h20;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " lcd_en"},     32'(lcd_en), 0);
      check({tag, " lcd_rs"},     32'(lcd_rs), 0);
      check({tag, " lcd_rw"},     32'(lcd_rw), 0);
      check({tag, " lcd_data"},   32'(lcd_data), 0);
      check({tag, " busy"},       32'(busy), 1);
      check({tag, " frame_done"}, 32'(frame_done), 0);
   endtask

   // Called at a negedge right after resetn is released.
   task automatic check_power_up(input string tag);
      repeat (99) @(posedge clk);
      #1;
      check({tag, " pwr data"}, 32'(lcd_data), 0);
      check({tag, " pwr busy"}, 32'(busy), 1);
      @(posedge clk);
      #1;
      check({tag, " first cmd"}, 32'({lcd_rs, lcd_data}), 32'h038);
      check({tag, " en low at start"}, 32'(lcd_en), 0);
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (busy !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " frame started"}, 32'(n < 1000), 1);
      q.delete();
   endtask

   task automatic wait_done(input string tag, input int exp_len);
      int n = 0;
      while (frame_done !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " frame done seen"}, 32'(n < 2000), 1);
      if (exp_len > 0) check({tag, " frame len"}, 32'(n), 32'(exp_len));
      check({tag, " busy low at done"}, 32'(busy), 0);
   endtask

   task automatic check_idle(input string tag, input int cycles);
      int hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (busy) hi++;
      end
      check({tag, " stays idle"}, 32'(hi), 0);
   endtask

   task automatic check_frame(input string tag, input int c0, input int c1,
                              input logic [15:0] d0, input logic [15:0] d1);
      check({tag, " byte count"}, 32'(q.size()), 34);
      if (q.size() != 34) return;
      for (int r = 0; r < 2; r++) begin
         check($sformatf("%s r%0d addr", tag, r), 32'(q[r*17]), (r == 0) ? 32'h080 : 32'h0C0);
         for (int c = 0; c < 16; c++)
            check($sformatf("%s r%0d c%0d", tag, r, c), 32'(q[r*17+1+c]),
                  32'({1'b1, exp_char(c, (r == 0) ? c0 : c1, (r == 0) ? d0 : d1)}));
      end
   endtask

   task automatic pulse_refresh();
      force_refresh = 1'b1;
      @(negedge clk);
      force_refresh = 1'b0;
   endtask

   initial begin
      logic [7:0] cmds[5];
      int         n;

      vecs[0] = '{5'd4,  5'd9, 12,  7, 16'h3034, 16'h3039};
      vecs[1] = '{5'd0,  5'd5, -1, 11, 16'h2D2D, 16'h3035};
      vecs[2] = '{5'd12, 5'd2, -1, 14, 16'h2D2D, 16'h3032};
      vecs[3] = '{5'd7,  5'd3,  9, 13, 16'h3037, 16'h3033};
      vecs[4] = '{5'd10, 5'd8, -1,  8, 16'h2D2D, 16'h3038};
      vecs[5] = '{5'd9,  5'd9,  7,  7, 16'h3039, 16'h3039};
      cmds    = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

      resetn        = 1'b0;
      force_refresh = 1'b0;
      elv_floor     = {5'd9, 5'd1};
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // Power-up wait, command timing and lcd_en pulse width.
      resetn = 1'b1;
      check_power_up("init");
      repeat (2) @(posedge clk);
      #1;
      n = 0;
      while (lcd_en && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("init en width", 32'(n), 16);
      n = 0;
      while (busy !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("init idle reached", 32'(n < 500), 1);
      check("init cmd count", 32'(q.size()), 5);
      for (int i = 0; i < 5 && i < q.size(); i++)
         check($sformatf("init cmd%0d", i), 32'(q[i]), 32'({1'b0, cmds[i]}));

      wait_start("first");
      wait_done("first", 680);
      check_frame("first", 15, 7, 16'h3031, 16'h3039);

      for (int i = 0; i < 6; i++) begin
         elv_floor = {vecs[i].f1, vecs[i].f0};
         wait_start($sformatf("vec%0d", i));
         wait_done($sformatf("vec%0d", i), 680);
         check_frame($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].d0, vecs[i].d1);
      end

      // Floor change mid-frame: current frame unchanged, next frame follows automatically.
      elv_floor = {5'd9, 5'd1};
      wait_start("midchg a");
      repeat (100) @(negedge clk);
      elv_floor = {5'd9, 5'd4};
      wait_done("midchg a", 580);
      check_frame("midchg a", 15, 7, 16'h3031, 16'h3039);
      wait_start("midchg b");
      wait_done("midchg b", 680);
      check_frame("midchg b", 12, 7, 16'h3034, 16'h3039);

      // No request means no frame; a refresh pulse redraws once.
      check_idle("noreq", 200);
      pulse_refresh();
      wait_start("refresh");
      wait_done("refresh", 680);
      check_frame("refresh", 12, 7, 16'h3034, 16'h3039);
      check_idle("refresh", 200);

      // Refresh during a frame yields exactly one extra frame.
      pulse_refresh();
      wait_start("pend a");
      repeat (50) @(negedge clk);
      pulse_refresh();
      wait_done("pend a", 0);
      wait_start("pend b");
      wait_done("pend b", 680);
      check_frame("pend b", 12, 7, 16'h3034, 16'h3039);
      check_idle("pend", 200);

      // Reset at offset 10 of a character transaction.
      elv_floor = {5'd2, 5'd4};
      wait_start("rst");
      n = 0;
      while (!(lcd_rs && lcd_en) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst wrch found", 32'(n < 200), 1);
      repeat (8) @(posedge clk);
      #1;
      check("rst en before", 32'(lcd_en), 1);
      resetn = 1'b0;
      #1;
      check_reset_outputs("rst async");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      check_power_up("rst restart");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
